multicycle_sequencer: RTL and testbench

Multi-cycle FSM controller for the 16-bit CPU datapath, replacing single-cycle opcode decode with per-state control strobes. Sequences fetch, decode, execute, memory and writeback over the shared ALU, register file and a single unified memory port. Handles memory wait states with a bounded-wait timeout. Flags illegal opcodes.

---
 rtl/multicycle_sequencer_if.sv | 32 +++
 rtl/multicycle_sequencer.sv | 172 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multi-cycle sequencer (master) and the CPU datapath (slave).
interface multicycle_sequencer_if;
    logic [3:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       RegWrite;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] ALUOp;
    logic [2:0] State;
    logic       BusError;
    logic       Illegal;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemToReg, RegWrite, AluSrcA, AluSrcB, ALUOp, State, BusError, Illegal
    );
    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemToReg, RegWrite, AluSrcA, AluSrcB, ALUOp, State, BusError, Illegal
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FSM controller for the 16-bit CPU with bounded memory waits.
// ILLEGAL_TRAP_EN: when defined, an illegal opcode parks the FSM in TRAP until reset.
module multicycle_sequencer #(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic                    Clock,
    input  logic                    ResetN,
    multicycle_sequencer_if.master  bus
);
    localparam int CW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM_RD = 3'd3,
        MEM_WR = 3'd4, WB = 3'd5, BRANCH = 3'd6, TRAP = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_R = 3'd0, C_I = 3'd1, C_LW = 3'd2, C_SW = 3'd3, C_BEQ = 3'd4, C_ILL = 3'd5
    } cls_e;

    function automatic cls_e classify(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0010, 4'b0011, 4'b0100,
            4'b0110, 4'b0111, 4'b1100:          classify = C_R;
            4'b0001, 4'b0101, 4'b1101:          classify = C_I;
            4'b1000:                            classify = C_LW;
            4'b1001:                            classify = C_SW;
            4'b1111:                            classify = C_BEQ;
            default:                            classify = C_ILL;
        endcase
    endfunction

    state_e        state_q, state_d;
    cls_e          cls_q, cls_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;
    logic          illegal_q, illegal_d;
    logic          run_q, run_d;
    logic          mem_state, timeout;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= FETCH;
            cls_q     <= C_R;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
            run_q     <= run_d;
        end
    end

    assign mem_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timeout   = mem_state && !bus.MemReady && (cnt_q == CW'(WAIT_TIMEOUT));

    // run_q holds the FSM idle for the first cycle after reset release
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        cnt_d     = '0;
        bus_err_d = 1'b0;
        run_d     = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`else
        illegal_d = 1'b0;
`endif
        if (run_q) begin
            case (state_q)
                FETCH:  if (bus.MemReady) state_d = DECODE;
                DECODE: begin
                    cls_d = classify(bus.Opcode);
                    case (cls_d)
                        C_BEQ:   state_d = BRANCH;
                        C_ILL: begin
                            illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                            state_d   = TRAP;
`else
                            state_d   = FETCH;
`endif
                        end
                        default: state_d = EXEC;
                    endcase
                end
                EXEC: begin
                    if (cls_q == C_LW)      state_d = MEM_RD;
                    else if (cls_q == C_SW) state_d = MEM_WR;
                    else                    state_d = WB;
                end
                MEM_RD: if (bus.MemReady) state_d = WB;
                MEM_WR: if (bus.MemReady) state_d = FETCH;
                TRAP:   state_d = TRAP;
                default: state_d = FETCH;
            endcase
            // completion beats timeout: timeout already requires MemReady low
            if (timeout) begin
                state_d   = FETCH;
                bus_err_d = 1'b1;
            end else if (mem_state && !bus.MemReady) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        bus.PCWrite  = 1'b0;
        bus.PCSource = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemToReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.AluSrcA  = 1'b0;
        bus.AluSrcB  = 2'b00;
        bus.ALUOp    = 2'b00;
        if (run_q) begin
            case (state_q)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.AluSrcB = 2'b01;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                end
                DECODE: bus.AluSrcB = 2'b11;
                EXEC: begin
                    bus.AluSrcA = 1'b1;
                    if (cls_q == C_R) begin
                        bus.ALUOp = 2'b10;
                    end else if (cls_q == C_I) begin
                        bus.AluSrcB = 2'b10;
                        bus.ALUOp   = 2'b11;
                    end else begin
                        bus.AluSrcB = 2'b10;
                    end
                end
                MEM_RD: begin
                    bus.IorD    = 1'b1;
                    bus.MemRead = 1'b1;
                end
                MEM_WR: begin
                    bus.IorD     = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                WB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = (cls_q == C_R);
                    bus.MemToReg = (cls_q == C_LW);
                end
                BRANCH: begin
                    bus.AluSrcA  = 1'b1;
                    bus.ALUOp    = 2'b01;
                    bus.PCSource = 1'b1;
                    bus.PCWrite  = bus.Zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.State    = state_q;
    assign bus.BusError = bus_err_q;
    assign bus.Illegal  = illegal_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: per-cycle expected control words queued by stimulus, checked by a negedge monitor.
module tb_multicycle_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    multicycle_sequencer_if bus();

    multicycle_sequencer #(.WAIT_TIMEOUT(15)) dut (.Clock(clk), .ResetN(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // {State, PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
    //  RegWrite, AluSrcA, AluSrcB, ALUOp, BusError, Illegal}
    logic [18:0] act;
    assign act = {bus.State, bus.PCWrite, bus.PCSource, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.RegDst, bus.MemToReg, bus.RegWrite, bus.AluSrcA,
                  bus.AluSrcB, bus.ALUOp, bus.BusError, bus.Illegal};

    localparam logic [18:0] ZERO   = 19'd0;
    localparam logic [18:0] BE     = 19'd2;
    localparam logic [18:0] IL     = 19'd1;
    //                                 st    pcw  pcs  iord mr   mw   irw  rd   m2r  rw   asa  asb    aop
    localparam logic [18:0] F_WAIT = {3'd0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
    localparam logic [18:0] F_DONE = {3'd0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
    localparam logic [18:0] DEC    = {3'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00};
    localparam logic [18:0] EX_R   = {3'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00};
    localparam logic [18:0] EX_I   = {3'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b11,2'b00};
    localparam logic [18:0] EX_M   = {3'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00};
    localparam logic [18:0] MRD    = {3'd3,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
    localparam logic [18:0] MWR    = {3'd4,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
    localparam logic [18:0] WB_R   = {3'd5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
    localparam logic [18:0] WB_I   = {3'd5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
    localparam logic [18:0] WB_L   = {3'd5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00};
    localparam logic [18:0] BR_T   = {3'd6,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b00};
    localparam logic [18:0] BR_N   = {3'd6,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b00};
`ifdef ILLEGAL_TRAP_EN
    localparam logic [18:0] TRAPV  = {3'd7,16'd0};
`endif

    typedef struct {
        string       tag;
        logic [18:0] v;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            vectors++;
            if (act !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", e.tag, act, e.v);
            end
        end
    end

    // one cycle: drive MemReady, queue the expected control word, advance to posedge+1
    task automatic cyc(input string tag, input logic mr, input logic [18:0] e);
        exp_t x;
        bus.MemReady = mr;
        x.tag = tag;
        x.v   = e;
        sbq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.Opcode   = 4'd0;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 1'b1, ZERO);
        rst_n = 1'b1;
        cyc("release", 1'b1, ZERO);

        // ADD, zero wait
        bus.Opcode = 4'b0100;
        cyc("add_fetch", 1'b1, F_DONE);
        cyc("add_dec",   1'b1, DEC);
        cyc("add_exec",  1'b1, EX_R);
        cyc("add_wb",    1'b1, WB_R);

        // LW with three wait cycles in MEM_RD
        bus.Opcode = 4'b1000;
        cyc("lw_fetch", 1'b1, F_DONE);
        cyc("lw_dec",   1'b1, DEC);
        cyc("lw_exec",  1'b1, EX_M);
        repeat (3) cyc("lw_wait", 1'b0, MRD);
        cyc("lw_rd",    1'b1, MRD);
        cyc("lw_wb",    1'b1, WB_L);

        // SW, zero wait
        bus.Opcode = 4'b1001;
        cyc("sw_fetch", 1'b1, F_DONE);
        cyc("sw_dec",   1'b1, DEC);
        cyc("sw_exec",  1'b1, EX_M);
        cyc("sw_wr",    1'b1, MWR);

        // SUBI, I-class
        bus.Opcode = 4'b1101;
        cyc("subi_fetch", 1'b1, F_DONE);
        cyc("subi_dec",   1'b1, DEC);
        cyc("subi_exec",  1'b1, EX_I);
        cyc("subi_wb",    1'b1, WB_I);

        // BEQ taken / not taken; MemReady low outside memory states is ignored
        bus.Opcode = 4'b1111;
        bus.Zero   = 1'b1;
        cyc("beq1_fetch", 1'b1, F_DONE);
        cyc("beq1_dec",   1'b0, DEC);
        cyc("beq1_br",    1'b0, BR_T);
        bus.Zero   = 1'b0;
        cyc("beq0_fetch", 1'b1, F_DONE);
        cyc("beq0_dec",   1'b1, DEC);
        cyc("beq0_br",    1'b1, BR_N);

        // LW completing on the same edge the counter reaches the limit
        bus.Opcode = 4'b1000;
        cyc("lwto_fetch", 1'b1, F_DONE);
        cyc("lwto_dec",   1'b1, DEC);
        cyc("lwto_exec",  1'b1, EX_M);
        repeat (15) cyc("lwto_wait", 1'b0, MRD);
        cyc("lwto_rd",    1'b1, MRD);
        cyc("lwto_wb",    1'b1, WB_L);

        // FETCH timeout twice in a row, then completion
        bus.Opcode = 4'b0100;
        repeat (16) cyc("fto_wait1", 1'b0, F_WAIT);
        cyc("fto_berr1", 1'b0, F_WAIT | BE);
        repeat (15) cyc("fto_wait2", 1'b0, F_WAIT);
        cyc("fto_berr2", 1'b1, F_DONE | BE);
        cyc("fto_dec",   1'b1, DEC);
        cyc("fto_exec",  1'b1, EX_R);
        cyc("fto_wb",    1'b1, WB_R);

        // illegal opcode
        bus.Opcode = 4'b1110;
        cyc("ill_fetch", 1'b1, F_DONE);
        cyc("ill_dec",   1'b1, DEC);
`ifdef ILLEGAL_TRAP_EN
        repeat (3) cyc("ill_trap", 1'b1, TRAPV | IL);
        rst_n = 1'b0;
        cyc("trap_reset", 1'b1, ZERO);
        rst_n = 1'b1;
        cyc("trap_release", 1'b1, ZERO);
`else
        cyc("ill_pulse", 1'b0, F_WAIT | IL);
        cyc("ill_after", 1'b0, F_WAIT);
`endif

        // reset in the middle of a MEM_WR wait
        bus.Opcode = 4'b1001;
        cyc("swr_fetch", 1'b1, F_DONE);
        cyc("swr_dec",   1'b1, DEC);
        cyc("swr_exec",  1'b1, EX_M);
        repeat (2) cyc("swr_wait", 1'b0, MWR);
        rst_n = 1'b0;
        cyc("swr_reset", 1'b0, ZERO);
        cyc("swr_hold",  1'b0, ZERO);
        rst_n = 1'b1;
        cyc("swr_release", 1'b0, ZERO);
        bus.Opcode = 4'b0100;
        repeat (16) cyc("post_wait", 1'b0, F_WAIT);
        cyc("post_berr", 1'b1, F_DONE | BE);
        cyc("post_dec",  1'b1, DEC);
        cyc("post_exec", 1'b1, EX_R);
        cyc("post_wb",   1'b1, WB_R);
        cyc("post_fetch", 1'b0, F_WAIT);

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
